// File: rtl/npu_cmd_arbiter.sv
// Round-robin sequencer for the shared NPU engine between the core handshake and a host command port.
// Optional perf counters are enabled with `define NPU_CTRL_PERF_EN.
module npu_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16,
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_start_matrix_mul,
  input  logic              cpu_start_conv,
  output logic              cpu_npu_done,
  input  logic              host_req,
  input  logic [1:0]        host_op,
  output logic              host_gnt,
  output logic              host_done,
  output logic              eng_start,
  output logic [1:0]        eng_op,
  output logic              eng_abort,
  input  logic              eng_done,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic              busy
`ifdef NPU_CTRL_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_busy_cycles,
  output logic [PERF_W-1:0] perf_ops
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic            WIN_CORE = 1'b0;
  localparam logic            WIN_HOST = 1'b1;
  localparam logic            TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Elaboration-time sanity: degenerate widths leave an empty marker block.
  if (CNT_W < 1 || PERF_W < 1) begin : g_bad_width
  end

  state_t           r_state, w_nxt;
  logic [1:0]       r_op;
  logic             r_winner;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic       w_core_req;
  logic [1:0] w_core_op;
  logic       w_host_vld;
  logic       w_pick_host;
  logic       w_grant;
  logic       w_timeout;

  // Matmul has priority over conv when the core raises both.
  assign w_core_req  = cpu_start_matrix_mul | cpu_start_conv;
  assign w_core_op   = cpu_start_matrix_mul ? 2'b01 : 2'b10;
  assign w_host_vld  = (host_op == 2'b01) || (host_op == 2'b10);
  assign w_pick_host = host_req && (!w_core_req || (r_last == WIN_CORE));
  assign w_grant     = (r_state == S_IDLE) && (w_core_req || host_req);
  assign w_timeout   = TO_EN && (r_state == S_WAIT) && (r_cnt == TO_LAST) && !eng_done;

  assign busy        = (r_state != S_IDLE);
  assign eng_op      = busy ? r_op : 2'b00;
  assign err_timeout = r_err;

  always_comb begin
    w_nxt        = r_state;
    host_gnt     = 1'b0;
    host_done    = 1'b0;
    cpu_npu_done = 1'b0;
    eng_start    = 1'b0;
    eng_abort    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          host_gnt = w_pick_host;
          // Invalid host ops skip the engine entirely but still get a done pulse.
          w_nxt    = (w_pick_host && !w_host_vld) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start = 1'b1;
        w_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          w_nxt = S_DONE;
        end else if (w_timeout) begin
          eng_abort = 1'b1;
          w_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        host_done    = (r_winner == WIN_HOST);
        cpu_npu_done = (r_winner == WIN_CORE);
        w_nxt        = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 2'b00;
      r_winner <= WIN_CORE;
      r_last   <= WIN_HOST;
      r_cnt    <= '0;
    end else begin
      if (w_grant) begin
        r_winner <= w_pick_host;
        if (!w_pick_host)    r_op <= w_core_op;
        else if (w_host_vld) r_op <= host_op;
        else                 r_op <= 2'b00;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_DONE)      r_last <= r_winner;
    end
  end

  // A timeout in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

`ifdef NPU_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_busy;
  logic [PERF_W-1:0] r_perf_ops;

  assign perf_busy_cycles = r_perf_busy;
  assign perf_ops         = r_perf_ops;

  // Invalid ops are latched as 00, so a nonzero op marks real engine work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_busy <= '0;
      r_perf_ops  <= '0;
    end else if (perf_clr) begin
      r_perf_busy <= '0;
      r_perf_ops  <= '0;
    end else begin
      if (busy && !(&r_perf_busy))
        r_perf_busy <= r_perf_busy + PERF_W'(1);
      if ((r_state == S_DONE) && (r_op != 2'b00) && !(&r_perf_ops))
        r_perf_ops <= r_perf_ops + PERF_W'(1);
    end
  end
`endif

endmodule
